// File: rtl/ccp_pkg.sv
// Coherence-protocol definitions shared by the L1.5 controller and its line array.
//   - MSG_TYPE_*: message encodings. Requests, write-backs and forward acks travel
//     cache->fabric (msg1/msg3); DATA_ACK and forwards travel fabric->cache (msg2).
//     Each forward ack reuses the code of the forward it answers, because the two
//     codes never share a channel.
//   - MESI_*: per-line coherence state.
//   - l15_state_e: controller FSM states.
package ccp_pkg;

   localparam logic [2:0] MSG_TYPE_EMPTY        = 3'd0;
   localparam logic [2:0] MSG_TYPE_LOAD_REQ     = 3'd1;
   localparam logic [2:0] MSG_TYPE_STORE_REQ    = 3'd2;
   localparam logic [2:0] MSG_TYPE_WB_REQ       = 3'd3;
   localparam logic [2:0] MSG_TYPE_DATA_ACK     = 3'd4;
   localparam logic [2:0] MSG_TYPE_INV_FWD      = 3'd5;
   localparam logic [2:0] MSG_TYPE_STORE_FWD    = 3'd6;
   localparam logic [2:0] MSG_TYPE_LOAD_FWD     = 3'd7;
   localparam logic [2:0] MSG_TYPE_INV_FWDACK   = 3'd5;
   localparam logic [2:0] MSG_TYPE_STORE_FWDACK = 3'd6;
   localparam logic [2:0] MSG_TYPE_LOAD_FWDACK  = 3'd7;

   typedef logic [1:0] mesi_t;
   localparam mesi_t MESI_I = 2'd0;
   localparam mesi_t MESI_S = 2'd1;
   localparam mesi_t MESI_E = 2'd2;
   localparam mesi_t MESI_M = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WB   = 3'd1,
      ST_REQ  = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4
   } l15_state_e;

endpackage

// File: rtl/l15_line_array.sv
// Direct-mapped line storage: NUM_LINES entries of {state, tag, data}.
// Ports:
//   rd_idx_i  -> rd_state_o/rd_tag_o/rd_data_o    combinational core-side read
//   fwd_idx_i -> fwd_state_o/fwd_tag_o/fwd_data_o combinational forward-side read
//   fill_*    full-line install (highest priority)
//   upd_*     state-only update (forwards, victim invalidation)
//   st_*      store-hit data write, state becomes M (lowest priority)
module l15_line_array
   import ccp_pkg::*;
#(
   parameter int unsigned NUM_LINES  = 4,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      rd_idx_i,
   output mesi_t                 rd_state_o,
   output logic [TAG_WIDTH-1:0]  rd_tag_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic [IDX_W-1:0]      fwd_idx_i,
   output mesi_t                 fwd_state_o,
   output logic [TAG_WIDTH-1:0]  fwd_tag_o,
   output logic [DATA_WIDTH-1:0] fwd_data_o,
   input  logic                  fill_en_i,
   input  logic [IDX_W-1:0]      fill_idx_i,
   input  mesi_t                 fill_state_i,
   input  logic [TAG_WIDTH-1:0]  fill_tag_i,
   input  logic [DATA_WIDTH-1:0] fill_data_i,
   input  logic                  upd_en_i,
   input  logic [IDX_W-1:0]      upd_idx_i,
   input  mesi_t                 upd_state_i,
   input  logic                  st_en_i,
   input  logic [IDX_W-1:0]      st_idx_i,
   input  logic [DATA_WIDTH-1:0] st_data_i
);

   mesi_t                 state_q [NUM_LINES];
   logic [TAG_WIDTH-1:0]  tag_q   [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_q  [NUM_LINES];

   assign rd_state_o  = state_q[rd_idx_i];
   assign rd_tag_o    = tag_q[rd_idx_i];
   assign rd_data_o   = data_q[rd_idx_i];
   assign fwd_state_o = state_q[fwd_idx_i];
   assign fwd_tag_o   = tag_q[fwd_idx_i];
   assign fwd_data_o  = data_q[fwd_idx_i];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            state_q[i] <= MESI_I;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else if (fill_en_i) begin
         state_q[fill_idx_i] <= fill_state_i;
         tag_q[fill_idx_i]   <= fill_tag_i;
         data_q[fill_idx_i]  <= fill_data_i;
      end else if (upd_en_i) begin
         state_q[upd_idx_i] <= upd_state_i;
      end else if (st_en_i) begin
         state_q[st_idx_i] <= MESI_M;
         data_q[st_idx_i]  <= st_data_i;
      end
   end

endmodule

// File: rtl/l15_dm_cache.sv
// Private direct-mapped L1.5 cache controller between core and coherence fabric.
// Ports:
//   clk, rst                      clock, async active-high reset
//   core_valid/core_ready         request handshake: a request transfers in any
//                                 cycle where both are high; core_we/tag/data are
//                                 sampled only then. core_ready is high only in
//                                 IDLE with no fabric message present.
//   core_resp_valid/core_resp_data one-cycle completion pulse with load data
//                                 (or the stored data for a store)
//   msg2_*                        fabric-to-cache, one message per cycle, never stalled
//   msg1_*                        LOAD/STORE requests, held from REQ until the fill
//   msg3_*                        write-backs and forward acks, one-cycle pulses
module l15_dm_cache
   import ccp_pkg::*;
#(
   parameter int unsigned NUM_LINES  = 4,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MSG_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_valid,
   output logic                  core_ready,
   input  logic                  core_we,
   input  logic [TAG_WIDTH-1:0]  core_tag,
   input  logic [DATA_WIDTH-1:0] core_data,
   output logic                  core_resp_valid,
   output logic [DATA_WIDTH-1:0] core_resp_data,
   input  logic [MSG_WIDTH-1:0]  msg2_type,
   input  logic [DATA_WIDTH-1:0] msg2_data,
   input  logic [TAG_WIDTH-1:0]  msg2_tag,
   output logic [MSG_WIDTH-1:0]  msg1_type,
   output logic [DATA_WIDTH-1:0] msg1_data,
   output logic [TAG_WIDTH-1:0]  msg1_tag,
   output logic [MSG_WIDTH-1:0]  msg3_type,
   output logic [DATA_WIDTH-1:0] msg3_data,
   output logic [TAG_WIDTH-1:0]  msg3_tag
);

   localparam int unsigned IDX_W = $clog2(NUM_LINES);

   l15_state_e            state_q;
   logic                  req_we_q;
   logic [TAG_WIDTH-1:0]  req_tag_q;
   logic [DATA_WIDTH-1:0] req_data_q;
   logic [MSG_WIDTH-1:0]  msg1_type_q;
   logic [DATA_WIDTH-1:0] msg1_data_q;
   logic [TAG_WIDTH-1:0]  msg1_tag_q;
   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_data_q;

   logic [IDX_W-1:0]      rd_idx, fwd_idx;
   mesi_t                 rd_state, fw_state;
   logic [TAG_WIDTH-1:0]  rd_tag, fw_tag;
   logic [DATA_WIDTH-1:0] rd_data, fw_data, fill_data;
   logic is_ack, is_inv, is_stf, is_ldf, is_fwd, fwd_match;
   logic accept, core_hit, fill_hit, wb_emit, st_hit_en;

   // Outside IDLE the core-side port looks at the line of the outstanding request,
   // which is also the victim slot.
   assign rd_idx  = (state_q == ST_IDLE) ? core_tag[IDX_W-1:0] : req_tag_q[IDX_W-1:0];
   assign fwd_idx = msg2_tag[IDX_W-1:0];

   assign is_ack    = (msg2_type == MSG_WIDTH'(MSG_TYPE_DATA_ACK));
   assign is_inv    = (msg2_type == MSG_WIDTH'(MSG_TYPE_INV_FWD));
   assign is_stf    = (msg2_type == MSG_WIDTH'(MSG_TYPE_STORE_FWD));
   assign is_ldf    = (msg2_type == MSG_WIDTH'(MSG_TYPE_LOAD_FWD));
   assign is_fwd    = is_inv || is_stf || is_ldf;
   assign fwd_match = is_fwd && (fw_tag == msg2_tag) && (fw_state != MESI_I);

   assign core_ready = (state_q == ST_IDLE) && (msg2_type == MSG_WIDTH'(MSG_TYPE_EMPTY));
   assign accept     = core_valid && core_ready;
   assign core_hit   = (rd_tag == core_tag) && (rd_state != MESI_I);
   assign st_hit_en  = accept && core_we && core_hit &&
                       ((rd_state == MESI_E) || (rd_state == MESI_M));
   assign fill_hit   = (state_q == ST_WAIT) && is_ack && (msg2_tag == req_tag_q);
   assign fill_data  = req_we_q ? req_data_q : msg2_data;

   // The victim is re-read live each WB cycle: a forward may have downgraded it,
   // in which case the write-back is dropped. A forward owns msg3, so WB waits.
   assign wb_emit = (state_q == ST_WB) && !is_fwd && (rd_state == MESI_M);

   always_comb begin
      msg3_type = MSG_WIDTH'(MSG_TYPE_EMPTY);
      msg3_tag  = '0;
      msg3_data = '0;
      if (is_fwd) begin
         msg3_tag  = msg2_tag;
         msg3_type = is_inv ? MSG_WIDTH'(MSG_TYPE_INV_FWDACK) :
                     is_stf ? MSG_WIDTH'(MSG_TYPE_STORE_FWDACK) :
                              MSG_WIDTH'(MSG_TYPE_LOAD_FWDACK);
         if (fwd_match && !is_inv) msg3_data = fw_data;
      end else if (wb_emit) begin
         msg3_type = MSG_WIDTH'(MSG_TYPE_WB_REQ);
         msg3_tag  = rd_tag;
         msg3_data = rd_data;
      end
   end

   l15_line_array #(
      .NUM_LINES (NUM_LINES),
      .TAG_WIDTH (TAG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (rd_idx),
      .rd_state_o  (rd_state),
      .rd_tag_o    (rd_tag),
      .rd_data_o   (rd_data),
      .fwd_idx_i   (fwd_idx),
      .fwd_state_o (fw_state),
      .fwd_tag_o   (fw_tag),
      .fwd_data_o  (fw_data),
      .fill_en_i   (fill_hit),
      .fill_idx_i  (req_tag_q[IDX_W-1:0]),
      .fill_state_i(req_we_q ? MESI_M : MESI_S),
      .fill_tag_i  (req_tag_q),
      .fill_data_i (fill_data),
      .upd_en_i    (fwd_match || wb_emit),
      .upd_idx_i   (fwd_match ? fwd_idx : rd_idx),
      .upd_state_i ((fwd_match && is_ldf) ? MESI_S : MESI_I),
      .st_en_i     (st_hit_en),
      .st_idx_i    (rd_idx),
      .st_data_i   (core_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         req_we_q     <= 1'b0;
         req_tag_q    <= '0;
         req_data_q   <= '0;
         msg1_type_q  <= MSG_WIDTH'(MSG_TYPE_EMPTY);
         msg1_data_q  <= '0;
         msg1_tag_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               resp_valid_q <= 1'b0;
               if (accept) begin
                  req_we_q   <= core_we;
                  req_tag_q  <= core_tag;
                  req_data_q <= core_data;
                  if (core_hit && !core_we) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= rd_data;
                  end else if (st_hit_en) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= core_data;
                  end else if (!core_hit && (rd_state == MESI_M)) begin
                     state_q <= ST_WB;
                  end else begin
                     // Plain miss, or store hit in S (upgrade without write-back).
                     state_q     <= ST_REQ;
                     msg1_type_q <= core_we ? MSG_WIDTH'(MSG_TYPE_STORE_REQ)
                                            : MSG_WIDTH'(MSG_TYPE_LOAD_REQ);
                     msg1_tag_q  <= core_tag;
                     msg1_data_q <= '0;
                  end
               end
            end
            ST_WB: begin
               if (!is_fwd) begin
                  state_q     <= ST_REQ;
                  msg1_type_q <= req_we_q ? MSG_WIDTH'(MSG_TYPE_STORE_REQ)
                                          : MSG_WIDTH'(MSG_TYPE_LOAD_REQ);
                  msg1_tag_q  <= req_tag_q;
                  msg1_data_q <= '0;
               end
            end
            ST_REQ: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (fill_hit) begin
                  state_q      <= ST_RESP;
                  msg1_type_q  <= MSG_WIDTH'(MSG_TYPE_EMPTY);
                  msg1_tag_q   <= '0;
                  msg1_data_q  <= '0;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= fill_data;
               end
            end
            ST_RESP: begin
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign msg1_type       = msg1_type_q;
   assign msg1_data       = msg1_data_q;
   assign msg1_tag        = msg1_tag_q;
   assign core_resp_valid = resp_valid_q;
   assign core_resp_data  = resp_data_q;

endmodule

// File: doc/l15_dm_cache.md
# l15_dm_cache

Parametrised private L1.5 cache controller: a direct-mapped array of NUM_LINES MESI lines between the core and the shared coherence fabric. It serves core loads and stores with a valid/ready handshake and returns load data. It issues LOAD/STORE requests on msg1 and write-backs and forward-acks on msg3, and services fabric forwards on msg2 per line. It supersedes the single-line L1.5, and adds load-data return, fill-state install, upgrade-on-S and deferred write-back under forward contention.

## Interface
- NUM_LINES, 4, line count; power of two, at least 2; IDX_W = log2(NUM_LINES)
- TAG_WIDTH, 8, address/tag width; index = tag[IDX_W-1:0], full tag stored per line
- DATA_WIDTH, 8, data per line
- MSG_WIDTH, 3, message type width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- core_valid  in  1  core request valid
- core_ready  out  1  controller accepts request this cycle
- core_we  in  1  0 = load, 1 = store
- core_tag  in  TAG_WIDTH  request address
- core_data  in  DATA_WIDTH  store data
- core_resp_valid  out  1  one-cycle completion pulse
- core_resp_data  out  DATA_WIDTH  load data; store data for a store completion
- msg2_type / msg2_data / msg2_tag  in  MSG_WIDTH / DATA_WIDTH / TAG_WIDTH  fabric-to-cache, one cycle per message, always accepted
- msg1_type / msg1_data / msg1_tag  out  same  request channel
- msg3_type / msg3_data / msg3_tag  out  same  response/write-back channel

## Operation
- Line state in {I, S, E, M}. Fills install S (load) or M (store). E is reserved: a store hit in E goes to M silently.
- FSM states: IDLE, WB, REQ, WAIT, RESP. core_ready = 1 only in IDLE with msg2_type == EMPTY.
- IDLE, accept (core_valid && core_ready), lines latched in a request register:
  - load hit (state != I, tag match) -> RESP with line data
  - store hit in E/M -> write core_data, state M, RESP
  - store hit in S -> REQ (upgrade, no write-back)
  - miss with victim in M -> WB; any other miss -> REQ
- WB: msg3 = WB_REQ, victim tag, victim data for one cycle; victim goes to I; -> REQ.
- REQ: msg1 = LOAD_REQ or STORE_REQ, request tag, msg1_data = 0; -> WAIT. msg1 holds until the fill.
- WAIT: on msg2 DATA_ACK with msg2_tag == request tag, write the line: tag, data = msg2_data (store overwrites with the latched core_data), state S or M. Clear msg1 to EMPTY -> RESP. A DATA_ACK with any other tag is ignored.
- RESP: core_resp_valid = 1 for one cycle -> IDLE.
- Forwards, any FSM state, on the line indexed by msg2_tag:
  - match = line tag == msg2_tag and state != I
  - INV_FWD -> I, reply INV_FWDACK
  - STORE_FWD -> I, reply STORE_FWDACK with line data
  - LOAD_FWD -> S, reply LOAD_FWDACK with line data
  - no match -> state unchanged, ack still sent with data 0
- msg3 is a one-cycle pulse; EMPTY otherwise.

## Timing
- Reset (async): all lines I with tag 0 and data 0; FSM IDLE; all msg outputs EMPTY/0; core_resp_valid 0; core_resp_data 0.
- Hit latency: accept at cycle N -> core_resp_valid at N+1.
- Miss: msg1 valid at N+1 (N+2 with write-back). A matching DATA_ACK at cycle A -> msg1 EMPTY and core_resp_valid at A+1.
- msg2 has priority on msg3. If a forward arrives while the FSM is in WB, the forward ack is sent and WB is held one more cycle.
  - If that forward hits the victim, the victim is updated first. A victim left in I or S skips the write-back -> REQ.
- A forward hitting the target line while in WAIT is applied; the later fill still installs normally.
- A DATA_ACK and a forward in the same cycle cannot occur (one msg2 per cycle).
- Reset asserted mid-miss abandons the request with no ack and no response.

## Structure
- Shared package ccp_pkg: MSG_TYPE_* encodings (EMPTY, LOAD_REQ, STORE_REQ, WB_REQ, DATA_ACK, INV_FWD, STORE_FWD, LOAD_FWD, and the three FWDACKs), MESI_* encodings, FSM state enum.
- Sub-module l15_line_array: NUM_LINES entries of {state, tag, data}, one combinational read port (core index), one forward read port (msg2 index), one write port with priority fill > forward > store hit.

## Test plan
- Load miss: after reset, load tag 0x05 -> msg1 LOAD_REQ tag 0x05. DATA_ACK 0x05 / 0xAA -> next cycle resp_data 0xAA, line 1 in S.
- Store upgrade: store 0x05 / 0x3C with line in S -> msg1 STORE_REQ 0x05, no WB. After DATA_ACK -> line M with data 0x3C, resp asserted.
- Dirty eviction: line 1 = M 0x05 / 0x3C; load 0x09 -> msg3 WB_REQ 0x05 / 0x3C, next cycle msg1 LOAD_REQ 0x09.
- Forward in WB: at the WB cycle, inject STORE_FWD 0x05 -> msg3 STORE_FWDACK 0x3C, victim I, no WB_REQ issued, msg1 LOAD_REQ 0x09 follows.
- Forward miss: LOAD_FWD 0x0D while line 1 holds 0x05 -> LOAD_FWDACK data 0, line 1 unchanged.
- Reset mid-WAIT: rst pulsed with msg1 pending -> all outputs 0, lines I, core_ready 1 after release.
